// File: rtl/pattern_scanner.sv
`default_nettype none
// ============================================================================
// pattern_scanner: walks a memory address range (with wrap-around), compares
// each word against a captured pattern and reports count / first hit.
// Revision: 1.0
// ============================================================================
module pattern_scanner #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] pat_a,
  input  logic [DATA_W-1:0] pat_b,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [DATA_W-1:0] data,
  output logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              flag,
  output logic              fin,
  output logic [ADDR_W:0]   result,
  output logic [ADDR_W-1:0] first_addr,
  output logic              hit_any
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);
  localparam logic [ADDR_W:0]   c_cnt_one  = (ADDR_W + 1)'(1);

  state_t              state_q, state_d;
  logic                start_q, start_d;
  logic                armed_q, armed_d;
  logic                en_q, en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                fin_q, fin_d;
  logic [ADDR_W:0]     result_q, result_d;
  logic [ADDR_W-1:0]   first_addr_q, first_addr_d;
  logic                hit_any_q, hit_any_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   pat_a_q, pat_a_d;
  logic [DATA_W-1:0]   pat_b_q, pat_b_d;
  logic [ADDR_W-1:0]   end_addr_q, end_addr_d;

  logic                launch;
  logic                match;

  // armed_q blocks a launch until start has been seen low at least once,
  // so a start level already high when reset releases does not fire.
  assign launch = start & ~start_q & armed_q;

  always_comb begin
    match = 1'b0;
    case (mode_q)
      2'b00:   match = (data == pat_a_q);
      2'b01:   match = ((data & pat_b_q) == (pat_a_q & pat_b_q));
      2'b10:   match = (data >= pat_a_q);
      default: match = (data >= pat_a_q) && (data <= pat_b_q);
    endcase
  end

  assign flag       = en_q & match;
  assign en         = en_q;
  assign addr       = addr_q;
  assign fin        = fin_q;
  assign result     = result_q;
  assign first_addr = first_addr_q;
  assign hit_any    = hit_any_q;

  always_comb begin
    state_d      = state_q;
    start_d      = start;
    armed_d      = armed_q | ~start;
    en_d         = en_q;
    addr_d       = addr_q;
    fin_d        = fin_q;
    result_d     = result_q;
    first_addr_d = first_addr_q;
    hit_any_d    = hit_any_q;
    mode_d       = mode_q;
    pat_a_d      = pat_a_q;
    pat_b_d      = pat_b_q;
    end_addr_d   = end_addr_q;

    case (state_q)
      IDLE, DONE: begin
        if (launch) begin
          mode_d       = mode;
          pat_a_d      = pat_a;
          pat_b_d      = pat_b;
          end_addr_d   = end_addr;
          result_d     = '0;
          first_addr_d = '0;
          hit_any_d    = 1'b0;
          fin_d        = 1'b0;
          en_d         = 1'b1;
          addr_d       = start_addr;
          state_d      = SCAN;
        end
      end
      SCAN: begin
        if (flag) begin
          result_d = result_q + c_cnt_one;
          if (!hit_any_q) begin
            first_addr_d = addr_q;
            hit_any_d    = 1'b1;
          end
        end
        if (addr_q == end_addr_q) begin
          en_d    = 1'b0;
          fin_d   = 1'b1;
          state_d = DONE;
        end else begin
          addr_d = addr_q + c_addr_one;
        end
      end
      default: begin
        en_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      armed_q      <= ~start;
      en_q         <= 1'b0;
      addr_q       <= '0;
      fin_q        <= 1'b0;
      result_q     <= '0;
      first_addr_q <= '0;
      hit_any_q    <= 1'b0;
      mode_q       <= '0;
      pat_a_q      <= '0;
      pat_b_q      <= '0;
      end_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      armed_q      <= armed_d;
      en_q         <= en_d;
      addr_q       <= addr_d;
      fin_q        <= fin_d;
      result_q     <= result_d;
      first_addr_q <= first_addr_d;
      hit_any_q    <= hit_any_d;
      mode_q       <= mode_d;
      pat_a_q      <= pat_a_d;
      pat_b_q      <= pat_b_d;
      end_addr_q   <= end_addr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pattern_scanner.sv
`default_nettype none
// ============================================================================
// tb_pattern_scanner: directed scans with a result scoreboard and a per-read
// address/flag monitor.
// Revision: 1.0
// ============================================================================
module tb_pattern_scanner;

  localparam int DATA_W = 10;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [1:0]        mode;
  logic [DATA_W-1:0] pat_a, pat_b;
  logic [ADDR_W-1:0] start_addr, end_addr;
  logic [DATA_W-1:0] data;
  logic              en, flag, fin, hit_any;
  logic [ADDR_W-1:0] addr, first_addr;
  logic [ADDR_W:0]   result;

  logic [DATA_W-1:0] mem [DEPTH];
  bit                exp_hit [DEPTH];
  logic [ADDR_W-1:0] exp_addr;

  typedef struct {
    int res;
    int fa;
    int hit;
    int n;
    int lcyc;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  pattern_scanner #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .pat_a(pat_a), .pat_b(pat_b), .start_addr(start_addr), .end_addr(end_addr),
    .data(data), .en(en), .addr(addr), .flag(flag), .fin(fin),
    .result(result), .first_addr(first_addr), .hit_any(hit_any)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign data = mem[addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: checks every read against the expected address walk and hit map,
  // and pops the scoreboard whenever fin rises.
  initial begin
    bit   fin_prev;
    exp_t e;
    fin_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (en) begin
        chk("scan_addr", 32'(addr), 32'(exp_addr));
        chk("scan_flag", 32'(flag), 32'(exp_hit[addr]));
        exp_addr = exp_addr + 1'b1;
      end else if (flag) begin
        chk("flag_without_en", 32'(flag), 32'd0);
      end
      if (fin && !fin_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_fin", 32'(fin), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result",     32'(result),     32'(e.res));
          chk("first_addr", 32'(first_addr), 32'(e.fa));
          chk("hit_any",    32'(hit_any),    32'(e.hit));
          chk("fin_latency", 32'(cyc - e.lcyc), 32'(e.n + 1));
        end
      end
      fin_prev = fin;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = '0;
      exp_hit[i] = 1'b0;
    end
  endtask

  task automatic run(input logic [1:0] m, input logic [9:0] a, input logic [9:0] b,
                     input logic [9:0] sa, input logic [9:0] ea,
                     input int res, input int fa, input int hit, input bit toggle_mid);
    exp_t e;
    int   n;
    bit   seen;
    n = int'((ea - sa) & 10'h3FF) + 1;
    @(negedge clk);
    mode = m; pat_a = a; pat_b = b; start_addr = sa; end_addr = ea;
    exp_addr = sa;
    e.res = res; e.fa = fa; e.hit = hit; e.n = n; e.lcyc = cyc;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scrambled inputs after launch must not affect the captured scan.
    mode = ~m; pat_a = ~a; pat_b = ~b; start_addr = ~sa; end_addr = ~ea;
    if (toggle_mid) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < n + 20; k++) begin
      if (fin) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      chk("fin_timeout", 32'(fin), 32'd1);
      void'(sb.pop_front());
    end
    repeat (3) @(negedge clk);
    chk("hold_fin",    32'(fin),    32'd1);
    chk("hold_en",     32'(en),     32'd0);
    chk("hold_result", 32'(result), 32'(res));
  endtask

  initial begin
    bit reached;
    rst = 1'b0; start = 1'b1; mode = '0; pat_a = '0; pat_b = '0;
    start_addr = '0; end_addr = '0; exp_addr = '0;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_fin", 32'(fin), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_first_addr", 32'(first_addr), 32'd0);
    chk("rst_hit_any", 32'(hit_any), 32'd0);
    chk("rst_flag", 32'(flag), 32'd0);
    // Release reset with start already high: no launch until toggled.
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_launch_high_start", 32'(en), 32'd0);
    start = 1'b0;
    @(negedge clk);

    // Exact match, full space, hits at 5/700/1023.
    mem[5] = 10'h155; mem[700] = 10'h155; mem[1023] = 10'h155;
    exp_hit[5] = 1; exp_hit[700] = 1; exp_hit[1023] = 1;
    run(2'b00, 10'h155, 10'h000, 10'd0, 10'd1023, 3, 5, 1, 1'b0);

    // Inverted range never matches, even on the bound values.
    clear_mem();
    mem[3] = 10'h100; mem[4] = 10'h0FF;
    run(2'b11, 10'h100, 10'h0FF, 10'd0, 10'd15, 0, 0, 0, 1'b0);

    // Wrap-around scan, every word matches.
    for (int i = 0; i < DEPTH; i++) exp_hit[i] = 1'b1;
    run(2'b10, 10'h000, 10'h000, 10'd1020, 10'd3, 8, 1020, 1, 1'b0);

    // Masked match; start re-pulsed during the scan is ignored.
    clear_mem();
    mem[9] = 10'h2FF; mem[10] = 10'h1FF; mem[11] = 10'h0FF;
    exp_hit[9] = 1;
    run(2'b01, 10'h200, 10'h300, 10'd0, 10'd20, 1, 9, 1, 1'b1);

    // Single word.
    clear_mem();
    mem[77] = 10'h155; exp_hit[77] = 1;
    run(2'b00, 10'h155, 10'h000, 10'd77, 10'd77, 1, 77, 1, 1'b0);

    // Range bounds are inclusive.
    clear_mem();
    mem[100] = 10'h00F; mem[101] = 10'h010; mem[102] = 10'h015;
    mem[103] = 10'h020; mem[104] = 10'h021; mem[105] = 10'h3FF;
    exp_hit[101] = 1; exp_hit[102] = 1; exp_hit[103] = 1;
    run(2'b11, 10'h010, 10'h020, 10'd100, 10'd109, 3, 101, 1, 1'b0);

    // Greater-or-equal boundary.
    clear_mem();
    mem[50] = 10'h1FF; mem[51] = 10'h200; mem[52] = 10'h3FF;
    exp_hit[51] = 1; exp_hit[52] = 1;
    run(2'b10, 10'h200, 10'h000, 10'd48, 10'd55, 2, 51, 1, 1'b0);

    // Reset mid-scan at address 400 with start held high.
    for (int i = 0; i < DEPTH; i++) exp_hit[i] = 1'b1;
    @(negedge clk);
    mode = 2'b10; pat_a = '0; pat_b = '0; start_addr = 10'd0; end_addr = 10'd1023;
    exp_addr = '0;
    start = 1'b1;
    reached = 1'b0;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      if (en && addr == 10'd400) begin
        reached = 1'b1;
        break;
      end
    end
    chk("reach_addr_400", 32'(reached), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_en", 32'(en), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_fin", 32'(fin), 32'd0);
    chk("abort_hit_any", 32'(hit_any), 32'd0);
    chk("abort_addr", 32'(addr), 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_relaunch_en", 32'(en), 32'd0);
    chk("abort_no_relaunch_fin", 32'(fin), 32'd0);
    start = 1'b0;
    @(negedge clk);

    // Toggled start launches normally after the abort.
    clear_mem();
    mem[77] = 10'h155; exp_hit[77] = 1;
    run(2'b00, 10'h155, 10'h000, 10'd77, 10'd77, 1, 77, 1, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
